// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: controller states, frame
// geometry and the frame builder used at byte capture.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } tx_state_t;

    localparam int FRAME_BITS  = 11;
    localparam int FRAME_TICKS = 12;
    localparam int START_POS   = 0;
    localparam int DATA_LSB    = 1;
    localparam int DATA_MSB    = 8;
    localparam int PARITY_POS  = 9;
    localparam int STOP_POS    = 10;

    // With parity disabled, bit 9 becomes a second stop bit.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0] data,
        input logic       parity_en,
        input logic       parity_odd
    );
        logic [FRAME_BITS-1:0] frame;
        frame                    = '0;
        frame[START_POS]         = 1'b0;
        frame[DATA_MSB:DATA_LSB] = data;
        frame[PARITY_POS]        = parity_en ? ((^data) ^ parity_odd) : 1'b1;
        frame[STOP_POS]          = 1'b1;
        return frame;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-tick generator: counts 0..CLKS_PER_BIT-1 while enabled and raises a
// registered tick in the cycle the count sits at its last value.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // The tick is set one count early so it is high exactly while cnt == LAST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            tick <= (cnt == PRE);
            cnt  <= (cnt == LAST) ? '0 : cnt + ONE;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: captures a byte, builds the 11-bit frame and drives
// load/shift/baud_clk of the downstream 12-bit shift register for 12 ticks.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tx_valid,
    input  logic [7:0]            tx_data,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] data_frame,
    output logic                  load,
    output logic                  shift,
    output logic                  baud_clk
);

    localparam logic [3:0] TICKS_LAST = 4'(FRAME_TICKS - 1);

    tx_state_t  state;
    tx_state_t  state_next;
    logic       accept;
    logic [3:0] tick_cnt;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state == ST_SHIFT),
        .clear   (state == ST_LOAD),
        .tick    (baud_clk)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The frame ends on the twelfth tick; the following cycle reports done.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    accept     = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (baud_clk && (tick_cnt == TICKS_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load       <= 1'b0;
            shift      <= 1'b0;
            data_frame <= '1;
            tick_cnt   <= '0;
        end else begin
            tx_ready <= (state_next == ST_IDLE);
            busy     <= (state_next != ST_IDLE);
            load     <= (state_next == ST_LOAD);
            shift    <= (state_next == ST_SHIFT);
            done     <= (state == ST_SHIFT) && (state_next == ST_IDLE);
            if (accept) begin
                data_frame <= build_frame(tx_data, PARITY_EN != 0, PARITY_ODD != 0);
            end
            if (state == ST_LOAD) begin
                tick_cnt <= '0;
            end else if ((state == ST_SHIFT) && baud_clk) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl: three configurations share one stimulus
// driver and are compared against a cycle-indexed frame model.
module tb_uart_tx_ctrl;

    logic        clk;
    logic        reset_n;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [1:0]  sel;

    logic        valid_a, valid_b, valid_c;
    logic        ready_a, busy_a, done_a, load_a, shift_a, baud_a;
    logic        ready_b, busy_b, done_b, load_b, shift_b, baud_b;
    logic        ready_c, busy_c, done_c, load_c, shift_c, baud_c;
    logic [10:0] frame_a, frame_b, frame_c;

    logic [5:0]  obs_ctrl;
    logic [10:0] obs_frame;
    logic [11:0] line_reg;

    int          checks;
    int          errors;
    longint      prev_acc;
    bit          gap_check;

    assign valid_a = tx_valid && (sel == 2'd0);
    assign valid_b = tx_valid && (sel == 2'd1);
    assign valid_c = tx_valid && (sel == 2'd2);

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .reset_n(reset_n), .tx_valid(valid_a), .tx_data(tx_data),
        .tx_ready(ready_a), .busy(busy_a), .done(done_a), .data_frame(frame_a),
        .load(load_a), .shift(shift_a), .baud_clk(baud_a)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .reset_n(reset_n), .tx_valid(valid_b), .tx_data(tx_data),
        .tx_ready(ready_b), .busy(busy_b), .done(done_b), .data_frame(frame_b),
        .load(load_b), .shift(shift_b), .baud_clk(baud_b)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
        .clk(clk), .reset_n(reset_n), .tx_valid(valid_c), .tx_data(tx_data),
        .tx_ready(ready_c), .busy(busy_c), .done(done_c), .data_frame(frame_c),
        .load(load_c), .shift(shift_c), .baud_clk(baud_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control vector order: {load, busy, shift, baud_clk, done, tx_ready}.
    always_comb begin
        obs_ctrl  = {load_a, busy_a, shift_a, baud_a, done_a, ready_a};
        obs_frame = frame_a;
        case (sel)
            2'd1: begin
                obs_ctrl  = {load_b, busy_b, shift_b, baud_b, done_b, ready_b};
                obs_frame = frame_b;
            end
            2'd2: begin
                obs_ctrl  = {load_c, busy_c, shift_c, baud_c, done_c, ready_c};
                obs_frame = frame_c;
            end
            default: ;
        endcase
    end

    // Downstream 12-bit register with an idle-1 bit below the frame; bit 0 is the line.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_reg <= '1;
        end else if (obs_ctrl[5]) begin
            line_reg <= {obs_frame, 1'b1};
        end else if (obs_ctrl[3] && obs_ctrl[2]) begin
            line_reg <= {1'b1, line_reg[11:1]};
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int cpb();
        return (sel == 2'd2) ? 2 : 4;
    endfunction

    function automatic logic model_parity(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        if (sel == 2'd2) return 1'b1;
        if (sel == 2'd1) return ((ones % 2) == 0);
        return ((ones % 2) == 1);
    endfunction

    // Line value after k ticks: idle, start, eight data bits LSB first, parity, stop.
    function automatic logic exp_line(input logic [7:0] b, input int k, input logic p);
        if (k == 0) return 1'b1;
        if (k == 1) return 1'b0;
        if (k <= 9) return b[k-2];
        if (k == 10) return p;
        return 1'b1;
    endfunction

    function automatic logic [5:0] exp_ctrl(input int t, input int c);
        logic [5:0] v;
        int last_tick;
        last_tick = 1 + 12 * c;
        v[5] = (t == 1);
        v[4] = (t >= 1) && (t <= last_tick);
        v[3] = (t >= 2) && (t <= last_tick);
        v[2] = (t >= 1 + c) && (t <= last_tick) && (((t - 1) % c) == 0);
        v[1] = (t == last_tick + 1);
        v[0] = (t == last_tick + 1);
        return v;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while ((obs_ctrl[0] !== 1'b1) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_output("ready_timeout", 32'(obs_ctrl[0]), 32'd1);
    endtask

    // Sends one byte and checks every cycle of its frame. Called at a negedge.
    task automatic apply_stimulus(input logic [7:0] b, input bit keep_valid,
                                  input logic [7:0] next_b, input bit junk);
        int          c;
        int          last;
        logic        p;
        logic [10:0] f;
        longint      acc;
        c    = cpb();
        last = 2 + 12 * c;
        p    = model_parity(b);
        f    = {1'b1, p, b, 1'b0};
        wait_ready();
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        acc = longint'($time);
        if (gap_check) check_output("accept_gap", 32'((acc - prev_acc) / 10), 32'(last));
        prev_acc = acc;
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            if (t == 1) begin
                if (keep_valid) tx_data = next_b;
                else tx_valid = 1'b0;
            end
            if (junk && (t == 3 * c)) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
            end
            if (junk && (t == 3 * c + 2)) tx_valid = 1'b0;
            check_output($sformatf("ctrl_frame s%0d t%0d", sel, t),
                         32'({obs_ctrl, obs_frame}), 32'({exp_ctrl(t, c), f}));
            if ((t >= 2) && (((t - 2) % c) == 0) && (((t - 2) / c) <= 11))
                check_output($sformatf("line s%0d k%0d", sel, (t - 2) / c),
                             32'(line_reg[0]), 32'(exp_line(b, (t - 2) / c, p)));
        end
    endtask

    // Starts a frame, asserts reset in the tick-6 cycle and checks recovery.
    task automatic apply_reset_mid(input logic [7:0] b);
        int c;
        c = cpb();
        wait_ready();
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 1 + 6 * c; t++) begin
            @(negedge clk);
            if (t == 1) tx_valid = 1'b0;
        end
        check_output("tick6_baud", 32'(obs_ctrl[2]), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_output("reset_mid", 32'({obs_ctrl, obs_frame}), 32'({6'b0, 11'h7FF}));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("reset_hold", 32'({obs_ctrl, obs_frame}), 32'({6'b0, 11'h7FF}));
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_output("post_reset", 32'({obs_ctrl, obs_frame}), 32'({6'b000001, 11'h7FF}));
    endtask

    initial begin
        logic [7:0] b1, b2, b3;
        checks    = 0;
        errors    = 0;
        prev_acc  = 0;
        gap_check = 1'b0;
        reset_n   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        sel       = 2'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1 check_output($sformatf("reset s%0d", s),
                            32'({obs_ctrl, obs_frame}), 32'({6'b0, 11'h7FF}));
        end
        sel = 2'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1 check_output($sformatf("ready_rise s%0d", s),
                            32'({obs_ctrl, obs_frame}), 32'({6'b000001, 11'h7FF}));
        end
        sel = 2'd0;
        @(negedge clk);

        apply_stimulus(8'hA5, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);

        b1 = 8'($urandom);
        b2 = 8'($urandom);
        b3 = 8'($urandom);
        apply_stimulus(b1, 1'b1, b2, 1'b0);
        gap_check = 1'b1;
        apply_stimulus(b2, 1'b1, b3, 1'b0);
        apply_stimulus(b3, 1'b0, 8'h00, 1'b0);
        gap_check = 1'b0;

        apply_stimulus(8'($urandom), 1'b0, 8'h00, 1'b1);
        apply_reset_mid(8'($urandom));
        apply_stimulus(8'($urandom), 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);

        sel = 2'd1;
        @(negedge clk);
        apply_stimulus(8'h07, 1'b0, 8'h00, 1'b0);
        apply_stimulus(8'($urandom), 1'b0, 8'h00, 1'b1);
        repeat (2) @(negedge clk);

        sel = 2'd2;
        @(negedge clk);
        apply_stimulus(8'h07, 1'b0, 8'h00, 1'b0);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        apply_stimulus(b1, 1'b1, b2, 1'b0);
        gap_check = 1'b1;
        apply_stimulus(b2, 1'b0, 8'h00, 1'b0);
        gap_check = 1'b0;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
